// File: rtl/dmem_stream_master_pkg.sv
// Shared definitions for the data-memory stream master: FSM encoding and
// memory geometry constants.
package dmem_stream_master_pkg;

  localparam int WORD_BYTES = 4;
  localparam int MEM_WORDS  = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_stream_master_addr_gen.sv
// Address/count bookkeeping for a run: loadable word address register that
// steps by one word, and a remaining-word down-counter with a last-word flag.
module dmem_stream_master_addr_gen
  import dmem_stream_master_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_cur,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_cur;
  logic [CNT_W-1:0]  r_rem;

  // Load on command accept, otherwise advance one word per transfer.
  // The address wraps at full ADDR_W width with no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_cur <= i_base;
      r_rem <= i_count;
    end else if (i_step) begin
      r_cur <= r_cur + ADDR_W'(WORD_BYTES);
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign o_cur  = r_cur;
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/dmem_stream_master.sv
// Initiator for the data-memory port. Walks a run of consecutive words,
// streaming them out (read run) or absorbing them (write run).
//
// Handshakes: every channel (cmd, rd, wr) transfers on a rising clock edge
// where valid and ready are both high. The initiator never withdraws valid
// or alters data while valid is high and ready is low; ready may be asserted
// independently of valid.
module dmem_stream_master
  import dmem_stream_master_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData,
  output logic              done,
  output state_t            dbg_state
);

  state_t            r_state;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_load;
  logic              w_cap;
  logic              w_wr_step;
  logic              w_step;
  logic              w_last;
  logic [ADDR_W-1:0] w_cur;
  logic [ADDR_W-1:0] w_base_aligned;

  // Command accept, read capture (output slot free or being emptied) and
  // write transfer are the only events that move the address generator.
  assign w_load         = (r_state == S_IDLE) && cmd_valid;
  assign w_cap          = (r_state == S_READ) && (!r_rd_valid || rd_ready);
  assign w_wr_step      = (r_state == S_WRITE) && wr_valid;
  assign w_step         = w_cap || w_wr_step;
  assign w_base_aligned = {cmd_base[ADDR_W-1:2], 2'b00};

  dmem_stream_master_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (Reset),
    .i_load  (w_load),
    .i_base  (w_base_aligned),
    .i_count (cmd_count),
    .i_step  (w_step),
    .o_cur   (w_cur),
    .o_last  (w_last)
  );

  // Control FSM plus the registered read-data slot. A capture always wins
  // over a drain of the slot on the same edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_cap) begin
        r_rd_data  <= ReadData;
        r_rd_valid <= 1'b1;
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_count == '0) r_state <= S_DONE;
            else if (cmd_write)  r_state <= S_WRITE;
            else                 r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_cap && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_rd_valid || rd_ready) r_state <= S_DONE;
        end
        S_WRITE: begin
          if (wr_valid && w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WRITE);
  assign MemRead   = (r_state == S_READ);
  assign MemWrite  = w_wr_step;
  assign Address   = ((r_state == S_READ) || (r_state == S_WRITE)) ? w_cur : '0;
  assign WriteData = (r_state == S_WRITE) ? wr_data : '0;
  assign done      = (r_state == S_DONE);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_stream_master.sv
// Directed bench for dmem_stream_master with a DataMemory model and
// queue-based scoreboards for streamed reads and memory writes.
module tb_dmem_stream_master;
  import dmem_stream_master_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 11;

  logic              clk;
  logic              Reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] ReadData;
  logic              done;
  state_t            dbg_state;

  int total = 0;
  int bad   = 0;
  int wr_pulses = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] waddr_q[$];
  logic [DATA_W-1:0] wdata_q[$];
  logic [ADDR_W-1:0] addr_log[$];

  logic [DATA_W-1:0] mem     [0:MEM_WORDS-1];
  logic [DATA_W-1:0] ref_mem [0:MEM_WORDS-1];

  dmem_stream_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DataMemory model ----------------
  assign ReadData = mem[Address[11:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[Address[11:2]] <= WriteData;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- monitors (mid-cycle) ----------------
  always @(negedge clk) begin
    if (!Reset) begin
      chk("strobe_excl", {63'd0, MemRead & MemWrite}, 64'd0);
      if (MemRead) addr_log.push_back(Address);
      if (MemWrite) begin
        wr_pulses++;
        if (waddr_q.size() == 0) begin
          chk("wr_unexpected", 64'(waddr_q.size()), 64'd1);
        end else begin
          chk("wr_addr", Address, waddr_q.pop_front());
          chk("wr_data", {32'd0, WriteData}, {32'd0, wdata_q.pop_front()});
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("rd_data", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input bit wr, input logic [ADDR_W-1:0] base, input int cnt);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = base;
    cmd_count = CNT_W'(cnt);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_base  = ADDR_W'($urandom);
    cmd_count = CNT_W'($urandom_range(0, 1023));
  endtask

  task automatic push_reads(input logic [ADDR_W-1:0] base, input int cnt);
    int idx;
    for (int i = 0; i < cnt; i++) begin
      idx = (int'(base[11:2]) + i) % MEM_WORDS;
      exp_q.push_back(ref_mem[idx]);
    end
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    waddr_q.push_back(addr);
    wdata_q.push_back(data);
    ref_mem[addr[11:2]] = data;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
  endtask

  task automatic check_log(input string tag, input logic [ADDR_W-1:0] exp_a[], input int len);
    chk({tag, "_len"}, 64'(addr_log.size()), 64'(len));
    for (int i = 0; i < len && i < addr_log.size(); i++) begin
      chk(tag, addr_log[i], exp_a[i]);
    end
  endtask

  task automatic finish_run(input string tag);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    step();
    chk({tag, "_done_once"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_addr_idle"}, Address, 64'd0);
    chk({tag, "_q_empty"}, 64'(exp_q.size() + waddr_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [ADDR_W-1:0] al[];
    logic [DATA_W-1:0] d;

    for (int i = 0; i < MEM_WORDS; i++) begin
      d = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0103);
      mem[i]     = d;
      ref_mem[i] = d;
    end

    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    rd_ready  = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 32'hDEAD_BEEF;

    // Reset state
    step();
    step();
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_memread", {63'd0, MemRead}, 64'd0);
    chk("rst_memwrite", {63'd0, MemWrite}, 64'd0);
    chk("rst_address", Address, 64'd0);
    chk("rst_writedata", {32'd0, WriteData}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    wr_valid = 1'b0;
    Reset    = 1'b0;
    step();

    // 1: read run 0x10 x4, consumer always ready
    rd_ready = 1'b1;
    addr_log.delete();
    push_reads(64'h10, 4);
    send_cmd(1'b0, 64'h10, 4);
    chk("t1_first_addr", Address, 64'h10);
    chk("t1_memread", {63'd0, MemRead}, 64'd1);
    wait_done(30, n);
    chk("t1_done_lat", 64'(n), 64'd5);
    al = new[4];
    al[0] = 64'h10; al[1] = 64'h14; al[2] = 64'h18; al[3] = 64'h1C;
    check_log("t1_addr", al, 4);
    finish_run("t1");

    // 2: read run 0x10 x3, consumer stalls two cycles after first word
    rd_ready = 1'b0;
    addr_log.delete();
    push_reads(64'h10, 3);
    send_cmd(1'b0, 64'h10, 3);
    chk("t2_rd_valid_c0", {63'd0, rd_valid}, 64'd0);
    step();
    chk("t2_rd_valid_c1", {63'd0, rd_valid}, 64'd1);
    chk("t2_rd_data_c1", {32'd0, rd_data}, {32'd0, ref_mem[4]});
    chk("t2_addr_hold_c1", Address, 64'h14);
    step();
    chk("t2_rd_data_c2", {32'd0, rd_data}, {32'd0, ref_mem[4]});
    chk("t2_addr_hold_c2", Address, 64'h14);
    chk("t2_memread_hold", {63'd0, MemRead}, 64'd1);
    step();
    rd_ready = 1'b1;
    wait_done(30, n);
    chk("t2_done_lat", 64'(n), 64'd3);
    al = new[5];
    al[0] = 64'h10; al[1] = 64'h14; al[2] = 64'h14; al[3] = 64'h14; al[4] = 64'h18;
    check_log("t2_addr", al, 5);
    finish_run("t2");

    // 3: write run 0x20 x3 with a one-cycle gap, then read back
    wr_pulses = 0;
    send_cmd(1'b1, 64'h20, 3);
    chk("t3_wr_ready", {63'd0, wr_ready}, 64'd1);
    d = $urandom;
    wr_valid = 1'b1; wr_data = d; push_write(64'h20, d);
    step();
    wr_valid = 1'b0; wr_data = $urandom;
    step();
    chk("t3_wr_ready_gap", {63'd0, wr_ready}, 64'd1);
    d = $urandom;
    wr_valid = 1'b1; wr_data = d; push_write(64'h24, d);
    step();
    d = $urandom;
    wr_data = d; push_write(64'h28, d);
    step();
    wr_valid = 1'b0;
    chk("t3_wr_ready_off", {63'd0, wr_ready}, 64'd0);
    finish_run("t3");
    chk("t3_pulses", 64'(wr_pulses), 64'd3);
    push_reads(64'h20, 3);
    send_cmd(1'b0, 64'h20, 3);
    wait_done(30, n);
    chk("t3rb_done_lat", 64'(n), 64'd4);
    finish_run("t3rb");

    // 4: empty runs, read and write
    wr_pulses = 0;
    addr_log.delete();
    send_cmd(1'b0, 64'h30, 0);
    wait_done(30, n);
    chk("t4_done_lat", 64'(n), 64'd0);
    finish_run("t4r");
    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    send_cmd(1'b1, 64'h30, 0);
    wait_done(30, n);
    chk("t4w_done_lat", 64'(n), 64'd0);
    finish_run("t4w");
    wr_valid = 1'b0;
    chk("t4_no_read", 64'(addr_log.size()), 64'd0);
    chk("t4_no_write", 64'(wr_pulses), 64'd0);

    // 5: run across the top of memory, and an unaligned base
    addr_log.delete();
    push_reads(64'hFF8, 4);
    send_cmd(1'b0, 64'hFF8, 4);
    wait_done(30, n);
    chk("t5_done_lat", 64'(n), 64'd5);
    al = new[4];
    al[0] = 64'hFF8; al[1] = 64'hFFC; al[2] = 64'h1000; al[3] = 64'h1004;
    check_log("t5_addr", al, 4);
    finish_run("t5");
    addr_log.delete();
    push_reads(64'h10, 1);
    send_cmd(1'b0, 64'h13, 1);
    wait_done(30, n);
    chk("t5u_done_lat", 64'(n), 64'd2);
    al = new[1];
    al[0] = 64'h10;
    check_log("t5u_addr", al, 1);
    finish_run("t5u");

    // random consumer back-pressure on a longer run
    push_reads(64'h100, 9);
    send_cmd(1'b0, 64'h100, 9);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      rd_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    rd_ready = 1'b1;
    finish_run("trnd");

    // 6: asynchronous reset in the middle of a read run
    push_reads(64'h40, 8);
    send_cmd(1'b0, 64'h40, 8);
    step();
    step();
    #1 Reset = 1'b1;
    #1;
    chk("t6_memread", {63'd0, MemRead}, 64'd0);
    chk("t6_address", Address, 64'd0);
    chk("t6_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("t6_rd_data", {32'd0, rd_data}, 64'd0);
    chk("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("t6_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    step();
    Reset = 1'b0;
    step();
    addr_log.delete();
    push_reads(64'h80, 2);
    send_cmd(1'b0, 64'h80, 2);
    wait_done(30, n);
    chk("t6_after_done_lat", 64'(n), 64'd3);
    al = new[2];
    al[0] = 64'h80; al[1] = 64'h84;
    check_log("t6_after_addr", al, 2);
    finish_run("t6after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
